// File: rtl/plab3_mem_prefetch_stream_gen.sv
// Sequential-stream prefetch generator: snoops demand reads, detects ascending line streams
// and issues PRELW requests to the prefetch buffer, draining its responses.
module plab3_mem_prefetch_stream_gen #(
    parameter int unsigned p_opaque_nbits = 8,
    parameter int unsigned p_degree       = 2,
    parameter int unsigned p_threshold    = 2,
    parameter int unsigned p_max_out      = 2
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      domain,
    input  logic                      en,
    input  logic                      obs_val,
    input  logic [2:0]                obs_type,
    input  logic [31:0]               obs_addr,
    output logic                      pfreq_val,
    input  logic                      pfreq_rdy,
    output logic [2:0]                pfreq_type,
    output logic [p_opaque_nbits-1:0] pfreq_opaque,
    output logic [31:0]               pfreq_addr,
    output logic                      pfreq_domain,
    input  logic                      pfresp_val,
    output logic                      pfresp_rdy,
    output logic                      busy,
    output logic [7:0]                drop_count
);

    localparam logic [2:0] c_type_read  = 3'd0;
    localparam logic [2:0] c_type_prelw = 3'd7;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ISSUE = 2'd1;
    localparam logic [1:0] S_DRAIN = 2'd2;

    localparam logic [1:0] c_thr = p_threshold[1:0];
    localparam logic [2:0] c_deg = p_degree[2:0];
    localparam logic [1:0] c_max = p_max_out[1:0];

    logic [1:0]                state_q, state_d;
    logic [27:0]               last_line_q, last_line_d;
    logic                      last_vld_q, last_vld_d;
    logic [1:0]                conf_q, conf_d;
    logic [27:0]               hwm_q, hwm_d;
    logic                      hwm_vld_q, hwm_vld_d;
    logic [1:0]                out_q, out_d;
    logic [p_opaque_nbits-1:0] seq_q, seq_d;
    logic [7:0]                drop_q, drop_d;
    logic [27:0]               cur_q, cur_d;
    logic [27:0]               end_q, end_d;
    logic                      dom_q, dom_d;
    logic                      rdy_q;

    logic [27:0] line, line_inc, hwm_inc, start_line, end_line;
    logic [8:0]  end_off;
    logic [1:0]  conf_new;
    logic        act, trigger, range_ok, fire, hs, resp;
    logic        unused_addr_bits;

    assign unused_addr_bits = ^obs_addr[3:0];

    always_comb begin
        line     = obs_addr[31:4];
        act      = obs_val && en && (obs_type == c_type_read);
        line_inc = line + 28'd1;
        hwm_inc  = hwm_q + 28'd1;

        if (last_vld_q && (line == last_line_q + 28'd1))
            conf_new = (conf_q == 2'd3) ? 2'd3 : conf_q + 2'd1;
        else if (line == last_line_q)
            conf_new = conf_q;
        else
            conf_new = '0;
        trigger = act && (conf_new >= c_thr);

        // Window end is clipped at the last line of the 4KB page.
        start_line = (hwm_vld_q && (hwm_inc > line_inc)) ? hwm_inc : line_inc;
        end_off    = {1'b0, line[7:0]} + {6'b0, c_deg};
        end_line   = end_off[8] ? {line[27:8], 8'hFF} : {line[27:8], end_off[7:0]};
        range_ok   = (start_line[27:8] == line[27:8]) && (start_line <= end_line);
        fire       = trigger && range_ok;

        hs   = pfreq_val && pfreq_rdy;
        resp = pfresp_val && rdy_q && (out_q != 2'd0);
    end

    always_comb begin
        state_d     = state_q;
        last_line_d = last_line_q;
        last_vld_d  = last_vld_q;
        conf_d      = conf_q;
        hwm_d       = hwm_q;
        hwm_vld_d   = hwm_vld_q;
        out_d       = out_q;
        seq_d       = seq_q;
        drop_d      = drop_q;
        cur_d       = cur_q;
        end_d       = end_q;
        dom_d       = dom_q;

        if (act) begin
            conf_d      = conf_new;
            last_line_d = line;
            last_vld_d  = 1'b1;
        end

        case ({hs, resp})
            2'b10:   out_d = out_q + 2'd1;
            2'b01:   out_d = out_q - 2'd1;
            default: out_d = out_q;
        endcase

        if ((state_q != S_IDLE) && fire && (drop_q != 8'hFF))
            drop_d = drop_q + 8'd1;

        case (state_q)
            S_IDLE: begin
                if (fire) begin
                    cur_d   = start_line;
                    end_d   = end_line;
                    dom_d   = domain;
                    state_d = S_ISSUE;
                end
            end
            S_ISSUE: begin
                if (hs) begin
                    seq_d     = seq_q + {{(p_opaque_nbits-1){1'b0}}, 1'b1};
                    hwm_d     = cur_q;
                    hwm_vld_d = 1'b1;
                    if (cur_q != end_q)
                        cur_d = cur_q + 28'd1;
                end
                // Abort wins over the detector update made in the same cycle.
                if (!en || (domain != dom_q)) begin
                    state_d    = S_DRAIN;
                    conf_d     = '0;
                    last_vld_d = 1'b0;
                end else if (hs && (cur_q == end_q)) begin
                    state_d = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (out_q == 2'd0)
                    state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= S_IDLE;
            last_line_q <= '0;
            last_vld_q  <= 1'b0;
            conf_q      <= '0;
            hwm_q       <= '0;
            hwm_vld_q   <= 1'b0;
            out_q       <= '0;
            seq_q       <= '0;
            drop_q      <= '0;
            cur_q       <= '0;
            end_q       <= '0;
            dom_q       <= 1'b0;
            rdy_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            last_line_q <= last_line_d;
            last_vld_q  <= last_vld_d;
            conf_q      <= conf_d;
            hwm_q       <= hwm_d;
            hwm_vld_q   <= hwm_vld_d;
            out_q       <= out_d;
            seq_q       <= seq_d;
            drop_q      <= drop_d;
            cur_q       <= cur_d;
            end_q       <= end_d;
            dom_q       <= dom_d;
            rdy_q       <= 1'b1;
        end
    end

    assign pfreq_val    = (state_q == S_ISSUE) && (out_q < c_max);
    assign pfreq_type   = c_type_prelw;
    assign pfreq_addr   = {cur_q, 4'b0000};
    assign pfreq_opaque = seq_q;
    assign pfreq_domain = dom_q;
    assign pfresp_rdy   = rdy_q;
    assign busy         = (state_q != S_IDLE);
    assign drop_count   = drop_q;

endmodule

// File: tb/tb_plab3_mem_prefetch_stream_gen.sv
// Bench for the stream prefetch generator: directed scenarios plus randomized streams
// checked cycle by cycle against a queue-based behavioural model.
module tb_plab3_mem_prefetch_stream_gen;

    localparam int DEG  = 2;
    localparam int THR  = 2;
    localparam int MAXO = 2;
    localparam logic [2:0] T_READ  = 3'd0;
    localparam logic [2:0] T_PRELW = 3'd7;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        domain = 1'b0;
    logic        en = 1'b0;
    logic        obs_val = 1'b0;
    logic [2:0]  obs_type = 3'd0;
    logic [31:0] obs_addr = '0;
    logic        pfreq_val;
    logic        pfreq_rdy = 1'b0;
    logic [2:0]  pfreq_type;
    logic [7:0]  pfreq_opaque;
    logic [31:0] pfreq_addr;
    logic        pfreq_domain;
    logic        pfresp_val = 1'b0;
    logic        pfresp_rdy;
    logic        busy;
    logic [7:0]  drop_count;

    plab3_mem_prefetch_stream_gen #(
        .p_opaque_nbits (8),
        .p_degree       (DEG),
        .p_threshold    (THR),
        .p_max_out      (MAXO)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .domain       (domain),
        .en           (en),
        .obs_val      (obs_val),
        .obs_type     (obs_type),
        .obs_addr     (obs_addr),
        .pfreq_val    (pfreq_val),
        .pfreq_rdy    (pfreq_rdy),
        .pfreq_type   (pfreq_type),
        .pfreq_opaque (pfreq_opaque),
        .pfreq_addr   (pfreq_addr),
        .pfreq_domain (pfreq_domain),
        .pfresp_val   (pfresp_val),
        .pfresp_rdy   (pfresp_rdy),
        .busy         (busy),
        .drop_count   (drop_count)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    // Model: mode 0 = idle, 1 = issuing lines from m_q, 2 = waiting for responses.
    int          m_mode;
    logic [27:0] m_q[$];
    logic [27:0] m_last;
    bit          m_last_vld;
    int          m_conf;
    logic [27:0] m_hwm;
    bit          m_hwm_vld;
    int          m_out;
    int          m_seq;
    int          m_drop;
    logic        m_dom;

    logic [31:0] issued[$];
    int          issued_op[$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic m_reset();
        m_mode = 0; m_q.delete(); m_last = '0; m_last_vld = 0; m_conf = 0;
        m_hwm = '0; m_hwm_vld = 0; m_out = 0; m_seq = 0; m_drop = 0; m_dom = 1'b0;
    endtask

    task automatic m_update(input bit exp_val);
        bit          hs, rsp, fire;
        int          pre, off, eoff;
        logic [27:0] line, s, e;
        hs   = exp_val && pfreq_rdy;
        rsp  = pfresp_val && (m_out > 0);
        fire = 0;
        pre  = m_mode;
        s = '0; e = '0;
        if (obs_val && en && obs_type == T_READ) begin
            line = obs_addr[31:4];
            if (m_last_vld && line == m_last + 28'd1) m_conf = (m_conf < 3) ? m_conf + 1 : 3;
            else if (line != m_last) m_conf = 0;
            m_last = line;
            m_last_vld = 1;
            if (m_conf >= THR) begin
                s = line + 28'd1;
                if (m_hwm_vld && (m_hwm + 28'd1 > s)) s = m_hwm + 28'd1;
                off  = int'(line[7:0]);
                eoff = off + DEG;
                if (eoff > 255) eoff = 255;
                e = {line[27:8], 8'(eoff)};
                fire = (s[27:8] == line[27:8]) && (s <= e);
            end
        end
        if (pre == 0) begin
            if (fire) begin
                for (int k = 0; k <= int'(e - s); k++) m_q.push_back(s + 28'(k));
                m_dom  = domain;
                m_mode = 1;
            end
        end else if (fire && m_drop < 255) begin
            m_drop++;
        end
        if (pre == 1) begin
            if (hs) begin
                m_hwm = m_q.pop_front();
                m_hwm_vld = 1;
                m_seq = (m_seq + 1) % 256;
            end
            if (!en || domain != m_dom) begin
                m_q.delete(); m_conf = 0; m_last_vld = 0; m_mode = 2;
            end else if (m_q.size() == 0) begin
                m_mode = 2;
            end
        end else if (pre == 2 && m_out == 0) begin
            m_mode = 0;
        end
        m_out = m_out + int'(hs) - int'(rsp);
    endtask

    task automatic step();
        bit exp_val;
        @(negedge clk);
        exp_val = (m_mode == 1) && (m_out < MAXO);
        check("pfreq_val", 32'(pfreq_val), 32'(exp_val));
        check("busy", 32'(busy), 32'(m_mode != 0));
        check("drop_count", 32'(drop_count), m_drop);
        check("pfresp_rdy", 32'(pfresp_rdy), 32'd1);
        check("pfreq_type", 32'(pfreq_type), 32'(T_PRELW));
        if (exp_val) begin
            check("pfreq_addr", pfreq_addr, {m_q[0], 4'b0000});
            check("pfreq_opaque", 32'(pfreq_opaque), 32'(m_seq % 256));
            check("pfreq_domain", 32'(pfreq_domain), 32'(m_dom));
        end
        if (pfreq_val && pfreq_rdy) begin
            issued.push_back(pfreq_addr);
            issued_op.push_back(int'(pfreq_opaque));
        end
        @(posedge clk);
        m_update(exp_val);
        #1;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_val"}, 32'(pfreq_val), 32'd0);
        check({tag, "_busy"}, 32'(busy), 32'd0);
        check({tag, "_drop"}, 32'(drop_count), 32'd0);
        check({tag, "_addr"}, pfreq_addr, 32'd0);
        check({tag, "_opaque"}, 32'(pfreq_opaque), 32'd0);
        check({tag, "_domain"}, 32'(pfreq_domain), 32'd0);
        check({tag, "_resp_rdy"}, 32'(pfresp_rdy), 32'd0);
    endtask

    task automatic do_reset();
        reset = 1'b0; obs_val = 1'b0; pfreq_rdy = 1'b0; pfresp_val = 1'b0;
        en = 1'b1; domain = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_reset_outputs("rst");
        m_reset();
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic read(input logic [31:0] a);
        obs_val = 1'b1; obs_type = T_READ; obs_addr = a;
        step();
        obs_val = 1'b0;
    endtask

    logic [31:0] nxt;
    int          r;

    initial begin
        do_reset();

        // Basic stream: three ascending reads trigger two prefetches.
        issued.delete(); issued_op.delete();
        pfreq_rdy = 1'b1;
        read(32'h100); read(32'h110); read(32'h120);
        repeat (4) step();
        check("t1_count", issued.size(), 32'd2);
        if (issued.size() >= 2) begin
            check("t1_addr0", issued[0], 32'h130);
            check("t1_addr1", issued[1], 32'h140);
            check("t1_op0", issued_op[0], 32'd0);
            check("t1_op1", issued_op[1], 32'd1);
        end
        check("t1_busy", 32'(busy), 32'd1);
        pfresp_val = 1'b1; step(); step();
        pfresp_val = 1'b0; step();
        check("t1_idle", 32'(busy), 32'd0);

        // Back-pressure: request must hold stable while rdy is low.
        issued.delete(); issued_op.delete();
        pfreq_rdy = 1'b0;
        read(32'h2000); read(32'h2010); read(32'h2020);
        repeat (5) step();
        check("t2_held_val", 32'(pfreq_val), 32'd1);
        check("t2_held_addr", pfreq_addr, 32'h2030);
        check("t2_none", issued.size(), 32'd0);
        pfreq_rdy = 1'b1;
        repeat (4) step();
        check("t2_count", issued.size(), 32'd2);
        if (issued.size() >= 2) begin
            check("t2_addr0", issued[0], 32'h2030);
            check("t2_addr1", issued[1], 32'h2040);
        end
        pfresp_val = 1'b1; repeat (3) step();
        pfresp_val = 1'b0; step();

        // Randomized streams with page-end hits, repeats, backward jumps and aborts.
        nxt = 32'h0001_0000;
        for (int i = 0; i < 3000; i++) begin
            obs_val = ($urandom_range(0, 99) < 60);
            if (obs_val) begin
                r = $urandom_range(0, 99);
                if (r < 70) begin
                    obs_addr = nxt; nxt = nxt + 32'd16;
                end else if (r < 78) begin
                    obs_addr = nxt - 32'd16;
                end else if (r < 86) begin
                    nxt = nxt + 32'($urandom_range(1, 64)) * 32'h1000 + 32'($urandom_range(0, 255)) * 32'd16;
                    obs_addr = nxt; nxt = nxt + 32'd16;
                end else if (r < 94) begin
                    nxt = ((nxt + 32'h1000) & 32'hFFFF_F000) | 32'h0000_0FC0;
                    obs_addr = nxt; nxt = nxt + 32'd16;
                end else begin
                    nxt = nxt - 32'h100;
                    obs_addr = nxt; nxt = nxt + 32'd16;
                end
                obs_addr[3:0] = 4'($urandom_range(0, 15));
            end
            obs_type   = ($urandom_range(0, 99) < 90) ? T_READ : 3'($urandom_range(1, 6));
            en         = ($urandom_range(0, 99) < 97);
            if ($urandom_range(0, 99) < 2) domain = ~domain;
            pfreq_rdy  = ($urandom_range(0, 99) < 70);
            pfresp_val = ($urandom_range(0, 99) < 40);
            step();
        end

        // Drop while issuing, then asynchronous reset with a request pending.
        do_reset();
        read(32'h5000); read(32'h5010); read(32'h5020); read(32'h5030);
        step();
        check("t5_drop", 32'(drop_count), 32'd1);
        @(negedge clk);
        check("t6_pre_val", 32'(pfreq_val), 32'd1);
        #2;
        reset = 1'b0;
        #1;
        check_reset_outputs("t6");
        m_reset();
        @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        repeat (3) step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
